alu_sched: RTL and testbench
============================

# alu_sched

Round-robin scheduler that shares the single-cycle-registered `Alu` between `NREQ` requesters (e.g. an instruction-execute stage and a debug/test port). It accepts one operation at a time through a valid/ready request handshake, drives the `Alu` operand and opcode inputs from latched registers, captures `out`/`zero`, and returns them to the winning requester through a held valid/ready response. Illegal opcodes are rejected without touching the `Alu`.

## Interface
- `NREQ`, 2: number of requesters (≥2).
- `DW`, 32: operand/result width; must equal the `Alu` width.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`  in  NREQ*DW  operand A, requester i at `[i*DW +: DW]`.
- `req_b`  in  NREQ*DW  operand B, same packing.
- `req_op`  in  NREQ*4  opcode, requester i at `[i*4 +: 4]`.
- `rsp_valid`  out  NREQ  one-hot response valid to the owning requester.
- `rsp_ready`  in  NREQ  per-requester response accept.
- `rsp_data`  out  DW  result (shared).
- `rsp_zero`  out  1  `Alu` zero flag for the result.
- `rsp_err`  out  1  1 = illegal opcode, `rsp_data` = 0.
- `alu_a`, `alu_b`  out  DW  to `Alu` `a_data`/`b_data`.
- `alu_op`  out  4  to `Alu` `alu_op`.
- `alu_out`  in  DW  from `Alu` `out`.
- `alu_zero`  in  1  from `Alu` `zero`.

## Operation
- Legal opcodes: AND 0000, OR 0001, ADD 0010, ADDI 0011, SUB 0110, SLT 0111, NOR 1100. Any other = illegal.
- FSM: IDLE → ISSUE → CAPT → RESP → IDLE; IDLE → RESP directly for an illegal opcode.
- IDLE: arbiter picks winner g among asserted `req_valid`, starting search at pointer `ptr`; `req_ready[g]`=1 combinationally. On handshake latch a, b, op, owner=g; `ptr` ← (g+1) mod NREQ.
- ISSUE: `alu_a/b/op` driven from latched registers; `Alu` registers the result on this cycle's closing edge.
- CAPT: `alu_a/b/op` still held; `alu_out`/`alu_zero` copied into `rsp_data`/`rsp_zero` on closing edge.
- RESP: `rsp_valid[owner]`=1, data/zero/err stable until `rsp_ready[owner]`=1; then → IDLE. `rsp_ready` of non-owners ignored.
- Illegal op: `rsp_err`=1, `rsp_data`=0, `rsp_zero`=1; `Alu` inputs unchanged.
- `ptr` advances only on a grant; with a single active requester it is granted every transaction.
- Requesters must hold `req_valid` and payload stable until `req_ready`; behaviour on withdrawal before ready is unspecified.

## Timing
- Reset (async, any state): state=IDLE, `ptr`=0, `req_ready`=0 (while `rst_n`=0), `rsp_valid`=0, `rsp_data`=0, `rsp_zero`=0, `rsp_err`=0, `alu_a`=`alu_b`=0, `alu_op`=0000. In-flight operation is dropped, no response.
- Legal op: request handshake in cycle 0 → `rsp_valid` high in cycle 3. Illegal op: `rsp_valid` high in cycle 1.
- `rsp_ready` high in the first RESP cycle → RESP lasts 1 cycle; next grant possible in the following cycle (cycle 4). Peak throughput: one legal op per 4 cycles.
- No request accepted outside IDLE; `req_ready` all-zero in ISSUE/CAPT/RESP.
- Simultaneous requests: strict round robin, no requester waits more than NREQ-1 grants.

## Structure
- Shared package `alu_pkg`: 4-bit opcode constants, `op_legal` function, FSM state encoding.
- Sub-module `rr_arbiter` (NREQ-wide request vector, pointer input, one-hot grant + index output); FSM, operand registers and response registers stay in `alu_sched`.
- `Alu` is instantiated by the parent, not inside this block.

## Test plan
- Single req0: a=7, b=5, op=AND → cycle 3 `rsp_valid`=01, `rsp_data`=5, zero=0; repeat with ADD → 12, SUB → 2, SLT → 0, OR → 7, NOR → 0xFFFFFFF8.
- a=5, b=7, SLT → `rsp_data`=1; a=5, b=5, SUB → 0, `rsp_zero`=1.
- Both requesters valid continuously, back-to-back: grants alternate 0,1,0,1 after reset; each `rsp_valid` reaches only its owner.
- Illegal op 1111 from req1 → `rsp_valid`=10 one cycle after handshake, `rsp_err`=1, `rsp_data`=0, `alu_op` unchanged.
- `rsp_ready` held low 5 cycles in RESP → data stable, `req_ready` stays 0, no second grant until accept.
- `rst_n` pulsed low in CAPT → all outputs at reset values immediately; after release, `ptr`=0 and the next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, legality check and FSM encoding for the ALU scheduler.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // True for the seven opcodes the Alu implements.
    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_ADDI, OP_SUB, OP_SLT, OP_NOR: op_legal = 1'b1;
            default:                                                op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr_i wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   gnt_idx_o,
    output logic            gnt_any_o
);

    // Rotating search starting at the pointer; the first hit locks the grant.
    always_comb begin
        int j;
        j         = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!gnt_any_o && req_i[j]) begin
                gnt_any_o = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = PW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one registered Alu between NREQ requesters: round-robin grant,
// operand latch, two-cycle Alu round trip, held response to the owner.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [3:0]        alu_op,
    input  logic [DW-1:0]     alu_out,
    input  logic              alu_zero
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, owner_q;
    logic [DW-1:0]   a_q, b_q, data_q;
    logic [3:0]      op_q;
    logic            zero_q, err_q;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [3:0]      win_op;
    logic            win_legal;
    logic            hs;
    logic            rsp_acc;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    assign win_op    = req_op[int'(gnt_idx)*4 +: 4];
    assign win_legal = op_legal(win_op);
    assign hs        = (state_q == S_IDLE) && gnt_any;
    assign rsp_acc   = (state_q == S_RESP) && rsp_ready[owner_q];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: illegal ops skip the Alu round trip and respond at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hs) state_d = win_legal ? S_ISSUE : S_RESP;
            S_ISSUE: state_d = S_CAPT;
            S_CAPT:  state_d = S_RESP;
            S_RESP:  if (rsp_acc) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: ready only while idle and out of reset; response goes to owner only.
    always_comb begin
        req_ready = ((state_q == S_IDLE) && rst_n) ? gnt : '0;
        rsp_valid = (state_q == S_RESP) ? (NREQ'(1) << owner_q) : '0;
        rsp_data  = data_q;
        rsp_zero  = zero_q;
        rsp_err   = err_q;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_op    = op_q;
    end

    // Pointer, owner, operand latch and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (hs) begin
                ptr_q   <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                owner_q <= gnt_idx;
                if (win_legal) begin
                    // Alu inputs only change for operations it will execute.
                    a_q  <= req_a[int'(gnt_idx)*DW +: DW];
                    b_q  <= req_b[int'(gnt_idx)*DW +: DW];
                    op_q <= win_op;
                end else begin
                    data_q <= '0;
                    zero_q <= 1'b1;
                    err_q  <= 1'b1;
                end
            end
            if (state_q == S_CAPT) begin
                data_q <= alu_out;
                zero_q <= alu_zero;
                err_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: queued requesters, a stand-in registered Alu and a
// transaction-level reference model checked every cycle.
module tb_alu_sched;

    localparam int NREQ = 2;
    localparam int DW   = 32;

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010, ADDI_ = 4'b0011;
    localparam logic [3:0] SUB_ = 4'b0110, SLT_ = 4'b0111, NOR_ = 4'b1100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*DW-1:0] req_a, req_b;
    logic [NREQ*4-1:0] req_op;
    logic [DW-1:0]     rsp_data, alu_a, alu_b;
    logic              rsp_zero, rsp_err;
    logic [3:0]        alu_op;
    logic [DW-1:0]     alu_out = '0;
    logic              alu_zero = 1'b0;

    alu_sched #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [3:0] op);
        case (op)
            AND_:        return a & b;
            OR_:         return a | b;
            ADD_, ADDI_: return a + b;
            SUB_:        return a - b;
            SLT_:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            NOR_:        return ~(a | b);
            default:     return '0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {AND_, OR_, ADD_, ADDI_, SUB_, SLT_, NOR_};
    endfunction

    // Stand-in for the parent's Alu: result registered on every rising edge.
    always @(posedge clk) begin
        alu_out  <= alu_fn(alu_a, alu_b, alu_op);
        alu_zero <= (alu_fn(alu_a, alu_b, alu_op) == '0);
    end

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    op;
    } op_t;

    op_t q0[$], q1[$];
    op_t cur[NREQ];
    bit  vld[NREQ];

    // Reference model: busy flag, cycles left before the response, owner, pointer.
    bit            m_busy;
    int            m_cnt, m_owner, m_ptr;
    logic [DW-1:0] m_data, m_a, m_b;
    logic          m_zero, m_err;
    logic [3:0]    m_op;

    int n_chk = 0, n_fail = 0;
    int rdy_mode = 0;
    int stall = 0;
    int dut_grants[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] op);
        op_t t;
        t.a = a; t.b = b; t.op = op;
        if (i == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    task automatic model_reset();
        m_busy = 0; m_cnt = 0; m_owner = 0; m_ptr = 0;
        m_data = '0; m_zero = 1'b0; m_err = 1'b0;
        m_a = '0; m_b = '0; m_op = '0;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model.
    task automatic cycle();
        int g;
        bit in_resp;
        logic [NREQ-1:0] e;
        if (!vld[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); vld[0] = 1; end
        if (!vld[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); vld[1] = 1; end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = vld[i];
            req_a[i*DW +: DW]    = cur[i].a;
            req_b[i*DW +: DW]    = cur[i].b;
            req_op[i*4 +: 4]     = cur[i].op;
        end
        in_resp = m_busy && (m_cnt == 0);
        case (rdy_mode)
            0:       rsp_ready = '1;
            1:       rsp_ready = NREQ'($urandom);
            default: rsp_ready = (in_resp && stall > 0) ? '0 : '1;
        endcase
        #1;
        g = -1;
        if (!m_busy)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && vld[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        chk("req_ready", req_ready, e);
        if (req_ready != '0) dut_grants.push_back(req_ready[1] ? 1 : 0);
        e = '0;
        if (in_resp) e[m_owner] = 1'b1;
        chk("rsp_valid", rsp_valid, e);
        if (in_resp) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_zero", rsp_zero, m_zero);
            chk("rsp_err", rsp_err, m_err);
        end
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
        if (g >= 0) begin
            vld[g]  = 0;
            m_ptr   = (g + 1) % NREQ;
            m_owner = g;
            m_busy  = 1;
            stall   = 5;
            if (is_legal(cur[g].op)) begin
                m_a = cur[g].a; m_b = cur[g].b; m_op = cur[g].op;
                m_data = alu_fn(cur[g].a, cur[g].b, cur[g].op);
                m_zero = (m_data == '0);
                m_err  = 1'b0;
                m_cnt  = 2;
            end else begin
                m_data = '0; m_zero = 1'b1; m_err = 1'b1;
                m_cnt  = 0;
            end
        end else if (m_busy) begin
            if (m_cnt > 0) m_cnt--;
            else if (rsp_ready[m_owner]) m_busy = 0;
            else if (stall > 0) stall--;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || vld[0] || vld[1] || m_busy) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, '0);
        chk({tag, "_rsp_valid"}, rsp_valid, '0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_rsp_zero"}, rsp_zero, 1'b0);
        chk({tag, "_rsp_err"}, rsp_err, 1'b0);
        chk({tag, "_alu_a"}, alu_a, '0);
        chk({tag, "_alu_b"}, alu_b, '0);
        chk({tag, "_alu_op"}, alu_op, 4'b0000);
    endtask

    initial begin
        int n;
        logic [3:0] ops [8];
        ops = '{AND_, OR_, ADD_, ADDI_, SUB_, SLT_, NOR_, 4'b1111};
        model_reset();
        vld[0] = 0; vld[1] = 0;
        cur[0] = '{a: '0, b: '0, op: '0};
        cur[1] = '{a: '0, b: '0, op: '0};
        req_valid = '1; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
        #2;
        chk_reset_outputs("por");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single-requester arithmetic.
        push(0, 7, 5, AND_); push(0, 7, 5, ADD_); push(0, 7, 5, SUB_);
        push(0, 7, 5, SLT_); push(0, 7, 5, OR_);  push(0, 7, 5, NOR_);
        push(0, 5, 7, SLT_); push(0, 5, 5, SUB_);
        drain(200);

        // Illegal opcode from requester 1, then a legal one.
        push(1, 32'h1234, 32'h55, 4'b1111);
        push(1, 3, 3, ADDI_);
        drain(100);

        // Response back-pressure: five cycles of rsp_ready low while the other waits.
        rdy_mode = 2;
        push(0, 100, 1, SUB_); push(1, 9, 9, SUB_); push(0, 2, 3, ADD_);
        drain(200);
        rdy_mode = 0;

        // Reset while the Alu result is being captured.
        push(1, 9, 4, SUB_);
        n = 0;
        while (!(m_busy && m_cnt == 1) && n < 20) begin cycle(); n++; end
        chk("reach_capt", (m_busy && m_cnt == 1), 1'b1);
        cur[0] = '{a: 32'd1, b: 32'd2, op: ADD_};
        vld[0] = 1; req_valid = 2'b01; req_a[DW-1:0] = 32'd1; req_b[DW-1:0] = 32'd2;
        req_op[3:0] = ADD_;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("capt_rst");
        @(negedge clk);
        chk_reset_outputs("held_rst");
        rst_n = 1'b1;
        model_reset();
        vld[0] = 0; vld[1] = 0;

        // Both requesters continuously valid: grants alternate from 0.
        dut_grants.delete();
        for (int i = 0; i < 3; i++) begin
            push(0, i, 1, ADD_);
            push(1, 10 + i, 1, SUB_);
        end
        drain(200);
        chk("grant_count", dut_grants.size(), 6);
        for (int i = 0; i < 4; i++)
            if (i < dut_grants.size()) chk($sformatf("grant_%0d", i), dut_grants[i], i % 2);

        // Random traffic with random response acceptance.
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            push(int'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom),
                 ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom),
                 ops[$urandom_range(0, 7)]);
        end
        drain(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
